// File: rtl/instruction_memory.sv
// Read-only instruction store with a registered, one-cycle fetch path.
// Define IMEM_PRELOAD_EN to preload words 0-7 with a fixed test program; otherwise every word reads as zero.
module instruction_memory #(
  parameter int unsigned MEM_SIZE_BYTES = 256,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  localparam int unsigned WORDS = MEM_SIZE_BYTES / 4;
  localparam int unsigned IDX_W = $clog2(WORDS);

`ifdef IMEM_PRELOAD_EN
  // Contents of the preloaded program; any word not listed here reads as zero.
  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [IDX_W-1:0] idx);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    case (idx)
      IDX_W'(0): w = DATA_WIDTH'(32'h009403b3);
      IDX_W'(1): w = DATA_WIDTH'(32'h40b503b3);
      IDX_W'(2): w = DATA_WIDTH'(32'h02d602b3);
      IDX_W'(3): w = DATA_WIDTH'(32'h0107c733);
      IDX_W'(4): w = DATA_WIDTH'(32'h013918b3);
      IDX_W'(5): w = DATA_WIDTH'(32'h016ada33);
      IDX_W'(6): w = DATA_WIDTH'(32'h019c7bb3);
      IDX_W'(7): w = DATA_WIDTH'(32'h01cded33);
      default:   w = '0;
    endcase
    return w;
  endfunction
`endif

  logic                  legal_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // Full-width compare: any set upper address bit makes the fetch out of range, so nothing aliases.
  always_comb begin
    legal_c = (addr_i[1:0] == 2'b00) && (addr_i < ADDR_WIDTH'(MEM_SIZE_BYTES));
`ifdef IMEM_PRELOAD_EN
    rd_word_c = rom_word(addr_i[IDX_W+1:2]);
`else
    rd_word_c = '0;
`endif
  end

  // Power-up value of the output registers is zero.
  logic [DATA_WIDTH-1:0] data_q  = '0;
  logic                  valid_q = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (legal_c) begin
      data_q  <= rd_word_c;
      valid_q <= 1'b1;
    end else begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed and randomized fetch checks for instruction_memory against a behavioural model.
module tb_instruction_memory;

  localparam int unsigned MEM_BYTES = 256;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data;
  logic        valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [MEM_BYTES/4];

  instruction_memory #(
    .MEM_SIZE_BYTES(MEM_BYTES),
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .addr_i (addr),
    .data_o (data),
    .valid_o(valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected fetch result for the inputs sampled at one edge.
  task automatic model_fetch(input logic r, input logic [31:0] a,
                             output logic [31:0] d, output logic v);
    if (!r && (a % 4 == 0) && (a < MEM_BYTES)) begin
      d = ref_mem[a / 4];
      v = 1'b1;
    end else begin
      d = 32'h0;
      v = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] exp_d, input logic exp_v);
    n_cmp++;
    assert (data === exp_d && valid === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: got data_o=%h valid_o=%b, expected data_o=%h valid_o=%b",
             tag, data, valid, exp_d, exp_v);
    end
  endtask

  // Apply one cycle of inputs, clock it in, and check the registered result 1ns after the edge.
  task automatic step(input string tag, input logic r, input logic [31:0] a);
    logic [31:0] exp_d;
    logic        exp_v;
    rst  = r;
    addr = a;
    model_fetch(r, a, exp_d, exp_v);
    @(posedge clk);
    #1;
    check(tag, exp_d, exp_v);
  endtask

  initial begin
    logic [31:0] ra;
    logic        rr;

    for (int i = 0; i < MEM_BYTES / 4; i++) ref_mem[i] = 32'h0;
`ifdef IMEM_PRELOAD_EN
    ref_mem[0] = 32'h009403b3;
    ref_mem[1] = 32'h40b503b3;
    ref_mem[2] = 32'h02d602b3;
    ref_mem[3] = 32'h0107c733;
    ref_mem[4] = 32'h013918b3;
    ref_mem[5] = 32'h016ada33;
    ref_mem[6] = 32'h019c7bb3;
    ref_mem[7] = 32'h01cded33;
`endif

    rst  = 1'b1;
    addr = 32'h0;
    #1;
    check("powerup", 32'h0, 1'b0);

    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 32'h0);

    for (int i = 0; i < 8; i++) step("preload", 1'b0, 32'(i * 4));

    step("unaligned", 1'b0, 32'h0000_0001);
    step("oor_256", 1'b0, 32'h0000_0100);
    step("oor_msb", 1'b0, 32'h8000_0000);
    step("boundary_fc", 1'b0, 32'h0000_00FC);
    step("unaligned_hi", 1'b0, 32'h0000_00FE);
    step("alias_256p8", 1'b0, 32'h0000_0108);

    step("mid_pre", 1'b0, 32'h0000_0008);
    step("mid_rst", 1'b1, 32'h0000_000C);
    step("mid_post", 1'b0, 32'h0000_000C);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        1:       ra = 32'($urandom_range(0, 255));
        2:       ra = 32'($urandom_range(32'hF0, 32'h10F));
        default: ra = $urandom;
      endcase
      rr = ($urandom_range(0, 15) == 0);
      step("random", rr, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
